// File: rtl/sfu_share_arb_if.sv
// Request, unit and result bundle between the two SFU requesters, the arbiter
// and the shared softplus_or_exp16 pipeline.
// slave modport: arbiter side. master modport: requesters plus unit side.
interface sfu_share_arb_if #(
  parameter int DW   = 16,
  parameter int TAGW = 4
);
  // softplus requester
  logic            s_valid_i;
  logic            s_ready_o;
  logic [DW-1:0]   s_x_i;
  logic [TAGW-1:0] s_tag_i;
  // exp requester
  logic            e_valid_i;
  logic            e_ready_o;
  logic [DW-1:0]   e_x_i;
  logic [TAGW-1:0] e_tag_i;
  // shared unit
  logic            u_valid_o;
  logic            u_mode_softplus_o;
  logic [DW-1:0]   u_x_o;
  logic [DW-1:0]   u_y_s_i;
  logic            u_valid_s_i;
  logic [DW-1:0]   u_y_e_i;
  logic            u_valid_e_i;
  // results back to the requesters (no backpressure)
  logic            s_res_valid_o;
  logic [DW-1:0]   s_res_o;
  logic [TAGW-1:0] s_res_tag_o;
  logic            e_res_valid_o;
  logic [DW-1:0]   e_res_o;
  logic [TAGW-1:0] e_res_tag_o;

  modport slave (
    input  s_valid_i, s_x_i, s_tag_i, e_valid_i, e_x_i, e_tag_i,
    input  u_y_s_i, u_valid_s_i, u_y_e_i, u_valid_e_i,
    output s_ready_o, e_ready_o, u_valid_o, u_mode_softplus_o, u_x_o,
    output s_res_valid_o, s_res_o, s_res_tag_o,
    output e_res_valid_o, e_res_o, e_res_tag_o
  );

  modport master (
    output s_valid_i, s_x_i, s_tag_i, e_valid_i, e_x_i, e_tag_i,
    output u_y_s_i, u_valid_s_i, u_y_e_i, u_valid_e_i,
    input  s_ready_o, e_ready_o, u_valid_o, u_mode_softplus_o, u_x_o,
    input  s_res_valid_o, s_res_o, s_res_tag_o,
    input  e_res_valid_o, e_res_o, e_res_tag_o
  );
endinterface

// File: rtl/sfu_share_arb.sv
// Purpose: time-shares one softplus_or_exp16 pipe between softplus and exp requesters.
// Latency: accept -> unit issue 1 cycle; accept -> result 1+PIPE_LAT cycles.
// Backpressure: bounded-burst round-robin readies, dropped while drain_i; results have none.
// Ports: clk/rstn (sync, active-low); io = requests, unit drive/return, results;
//   drain_i blocks accepts, drained_o = nothing in flight, err_o = sticky valid mismatch.
module sfu_share_arb #(
  parameter int DW        = 16,
  parameter int PIPE_LAT  = 33,
  parameter int TAGW      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rstn,
  sfu_share_arb_if.slave   io,
  input  logic             drain_i,
  output logic             drained_o,
  output logic             err_o
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int OW = $clog2(PIPE_LAT + 3);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN_S, OWN_E} state_t;

  typedef struct packed {
    logic            v;
    logic            own_s;
    logic [TAGW-1:0] tag;
  } tag_ent_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_s;   // 1: last grant went to softplus

  logic grant_s, grant_e;
  logic acc_s, acc_e, acc;

  // Grant: the owner keeps the slot until its burst is used up, but only if
  // the other side is actually waiting; otherwise it may continue indefinitely.
  always_comb begin
    grant_s = 1'b0;
    grant_e = 1'b0;
    case (state)
      OWN_S: begin
        if (io.s_valid_i && (cnt < CNT_MAX || !io.e_valid_i)) grant_s = 1'b1;
        else if (io.e_valid_i)                                 grant_e = 1'b1;
      end
      OWN_E: begin
        if (io.e_valid_i && (cnt < CNT_MAX || !io.s_valid_i)) grant_e = 1'b1;
        else if (io.s_valid_i)                                 grant_s = 1'b1;
      end
      default: begin
        if (io.s_valid_i && io.e_valid_i) begin
          grant_s = ~last_s;
          grant_e = last_s;
        end else begin
          grant_s = io.s_valid_i;
          grant_e = io.e_valid_i;
        end
      end
    endcase
  end

  assign io.s_ready_o = grant_s & ~drain_i & rstn;
  assign io.e_ready_o = grant_e & ~drain_i & rstn;
  assign acc_s = io.s_valid_i & io.s_ready_o;
  assign acc_e = io.e_valid_i & io.e_ready_o;
  assign acc   = acc_s | acc_e;

  // Arbitration state moves only on an accept, apart from falling back to
  // IDLE when nobody is requesting (and not draining).
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      cnt    <= '0;
      last_s <= 1'b0;
    end else if (acc_s) begin
      last_s <= 1'b1;
      if (state == OWN_S) begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      end else begin
        state <= OWN_S;
        cnt   <= CW'(1);
      end
    end else if (acc_e) begin
      last_s <= 1'b0;
      if (state == OWN_E) begin
        if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      end else begin
        state <= OWN_E;
        cnt   <= CW'(1);
      end
    end else if (!drain_i && state != IDLE && !io.s_valid_i && !io.e_valid_i) begin
      state <= IDLE;
    end
  end

  // Unit drive: operand and mode hold between issues.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      io.u_valid_o         <= 1'b0;
      io.u_x_o             <= '0;
      io.u_mode_softplus_o <= 1'b1;
    end else begin
      io.u_valid_o <= acc;
      if (acc) begin
        io.u_x_o             <= acc_s ? io.s_x_i : io.e_x_i;
        io.u_mode_softplus_o <= acc_s;
      end
    end
  end

  // Tag pipe: entry loaded at the accept edge reaches index PIPE_LAT in the
  // same cycle the unit presents the matching result.
  tag_ent_t pipe [PIPE_LAT+1];
  tag_ent_t head;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i <= PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: acc, own_s: acc_s, tag: (acc_s ? io.s_tag_i : io.e_tag_i)};
      for (int i = 1; i <= PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign head = pipe[PIPE_LAT];

  // Any disagreement between the expected and the observed unit valids is a
  // protocol error; the head is then not forwarded to either requester.
  logic mismatch;
  always_comb begin
    if (!head.v)         mismatch = io.u_valid_s_i | io.u_valid_e_i;
    else if (head.own_s) mismatch = ~io.u_valid_s_i | io.u_valid_e_i;
    else                 mismatch = ~io.u_valid_e_i | io.u_valid_s_i;
  end

  assign io.s_res_valid_o = head.v &  head.own_s & ~mismatch;
  assign io.e_res_valid_o = head.v & ~head.own_s & ~mismatch;
  assign io.s_res_o       = io.s_res_valid_o ? io.u_y_s_i : '0;
  assign io.e_res_o       = io.e_res_valid_o ? io.u_y_e_i : '0;
  assign io.s_res_tag_o   = io.s_res_valid_o ? head.tag   : '0;
  assign io.e_res_tag_o   = io.e_res_valid_o ? head.tag   : '0;

  always_ff @(posedge clk) begin
    if (!rstn)         err_o <= 1'b0;
    else if (mismatch) err_o <= 1'b1;
  end

  // In-flight count: retirement is tracked from the tag pipe, so a dropped
  // unit valid still retires its slot.
  logic [OW-1:0] out_cnt;
  always_ff @(posedge clk) begin
    if (!rstn)                 out_cnt <= '0;
    else if (acc && !head.v)   out_cnt <= out_cnt + OW'(1);
    else if (!acc && head.v)   out_cnt <= out_cnt - OW'(1);
  end

  assign drained_o = (out_cnt == '0);

endmodule

// File: tb/tb_sfu_share_arb.sv
module tb_sfu_share_arb;
  localparam int DW = 16;
  localparam int TAGW = 4;
  localparam int PL = 33;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic drain, drained, err;
  logic inj_e, drop;

  always #5 clk = ~clk;

  sfu_share_arb_if #(.DW(DW), .TAGW(TAGW)) io ();

  sfu_share_arb #(.DW(DW), .PIPE_LAT(PL), .TAGW(TAGW), .MAX_BURST(MB)) dut (
    .clk(clk), .rstn(rstn), .io(io.slave),
    .drain_i(drain), .drained_o(drained), .err_o(err)
  );

  // Behavioural unit: fixed PL-cycle pipe, softplus stand-in = x^5A5A, exp stand-in = x+0101.
  logic          mv [PL];
  logic          mm [PL];
  logic [DW-1:0] mx [PL];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < PL; i++) begin mv[i] <= 1'b0; mm[i] <= 1'b0; mx[i] <= '0; end
    end else begin
      mv[0] <= io.u_valid_o; mm[0] <= io.u_mode_softplus_o; mx[0] <= io.u_x_o;
      for (int i = 1; i < PL; i++) begin mv[i] <= mv[i-1]; mm[i] <= mm[i-1]; mx[i] <= mx[i-1]; end
    end
  end
  assign io.u_valid_s_i = mv[PL-1] &  mm[PL-1] & ~drop;
  assign io.u_valid_e_i = (mv[PL-1] & ~mm[PL-1] & ~drop) | inj_e;
  assign io.u_y_s_i = mx[PL-1] ^ 16'h5A5A;
  assign io.u_y_e_i = mx[PL-1] + 16'h0101;

  function automatic logic [DW-1:0] fs(input logic [DW-1:0] x); return x ^ 16'h5A5A; endfunction
  function automatic logic [DW-1:0] fe(input logic [DW-1:0] x); return x + 16'h0101; endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  typedef struct { logic [DW-1:0] x; logic m; } iss_t;
  typedef struct { logic [DW-1:0] r; logic [TAGW-1:0] t; } res_t;
  iss_t iss_q[$];
  res_t s_q[$];
  res_t e_q[$];

  task automatic exp_s(input logic [DW-1:0] x, input logic [TAGW-1:0] t, input bit with_res);
    iss_q.push_back('{x: x, m: 1'b1});
    if (with_res) s_q.push_back('{r: fs(x), t: t});
  endtask
  task automatic exp_e(input logic [DW-1:0] x, input logic [TAGW-1:0] t);
    iss_q.push_back('{x: x, m: 1'b0});
    e_q.push_back('{r: fe(x), t: t});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an issue or a result.
  initial begin
    iss_t ie;
    res_t re;
    forever begin
      @(negedge clk);
      #2;
      if (io.u_valid_o === 1'b1) begin
        if (iss_q.size() == 0) chk("unexpected_issue", 1, 0);
        else begin
          ie = iss_q.pop_front();
          chk("issue_x", io.u_x_o, ie.x);
          chk("issue_mode", io.u_mode_softplus_o, ie.m);
        end
      end
      if (io.s_res_valid_o === 1'b1) begin
        if (s_q.size() == 0) chk("unexpected_s_res", 1, 0);
        else begin
          re = s_q.pop_front();
          chk("s_res", io.s_res_o, re.r);
          chk("s_res_tag", io.s_res_tag_o, re.t);
        end
      end
      if (io.e_res_valid_o === 1'b1) begin
        if (e_q.size() == 0) chk("unexpected_e_res", 1, 0);
        else begin
          re = e_q.pop_front();
          chk("e_res", io.e_res_o, re.r);
          chk("e_res_tag", io.e_res_tag_o, re.t);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0;
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic wait_drained(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); #2; n++; end while (drained !== 1'b1 && n < 200);
    chk(nm, drained, 1);
  endtask

  task automatic chk_queues(input string nm);
    chk({nm, "_iss_left"}, iss_q.size(), 0);
    chk({nm, "_s_left"}, s_q.size(), 0);
    chk({nm, "_e_left"}, e_q.size(), 0);
  endtask

  initial begin
    int si, ei, n, dual, first, e_seen, cnt_res, quiet;
    bit hit;
    io.s_valid_i = 0; io.s_x_i = '0; io.s_tag_i = '0;
    io.e_valid_i = 0; io.e_x_i = '0; io.e_tag_i = '0;
    drain = 0; inj_e = 0; drop = 0;

    // Reset values, with both requests asserted during reset
    repeat (3) @(negedge clk);
    io.s_valid_i = 1; io.e_valid_i = 1;
    #1;
    chk("rst_s_ready", io.s_ready_o, 0);
    chk("rst_e_ready", io.e_ready_o, 0);
    chk("rst_u_valid", io.u_valid_o, 0);
    chk("rst_u_x", io.u_x_o, 0);
    chk("rst_u_mode", io.u_mode_softplus_o, 1);
    chk("rst_s_res_valid", io.s_res_valid_o, 0);
    chk("rst_e_res_valid", io.e_res_valid_o, 0);
    chk("rst_s_res", io.s_res_o, 0);
    chk("rst_s_res_tag", io.s_res_tag_o, 0);
    chk("rst_drained", drained, 1);
    chk("rst_err", err, 0);
    @(negedge clk); io.s_valid_i = 0; io.e_valid_i = 0; rstn = 1;

    // Single softplus request
    @(negedge clk);
    io.s_valid_i = 1; io.s_x_i = 16'h3C00; io.s_tag_i = 4'd5;
    #1 chk("t1_s_ready", io.s_ready_o, 1);
    exp_s(16'h3C00, 4'd5, 1);
    @(negedge clk); io.s_valid_i = 0;
    #2;
    chk("t1_u_valid", io.u_valid_o, 1);
    chk("t1_u_mode", io.u_mode_softplus_o, 1);
    first = 0; e_seen = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk); #2;
      if (io.s_res_valid_o && first == 0) first = k;
      if (io.e_res_valid_o) e_seen = 1;
    end
    chk("t1_latency", first, 34);
    chk("t1_e_res_quiet", e_seen, 0);

    // Both continuous from reset: S x4, E x4, S x4, E x4
    do_reset();
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) exp_s(16'(16'h1000 + 4*b + i), 4'(4*b + i), 1);
      for (int i = 0; i < 4; i++) exp_e(16'(16'h2000 + 4*b + i), 4'(15 - 4*b - i));
    end
    si = 0; ei = 0; n = 0; dual = 0;
    while ((si < 8 || ei < 8) && n < 100) begin
      @(negedge clk);
      io.s_valid_i = (si < 8); io.s_x_i = 16'(16'h1000 + si); io.s_tag_i = 4'(si);
      io.e_valid_i = (ei < 8); io.e_x_i = 16'(16'h2000 + ei); io.e_tag_i = 4'(15 - ei);
      #1;
      if (io.s_ready_o && io.e_ready_o) dual++;
      if (io.s_valid_i && io.s_ready_o) si++;
      if (io.e_valid_i && io.e_ready_o) ei++;
      n++;
    end
    @(negedge clk); io.s_valid_i = 0; io.e_valid_i = 0;
    chk("t2_cycles", n, 16);
    chk("t2_dual_grant", dual, 0);
    wait_drained("t2_drained");
    chk_queues("t2");
    chk("t2_err", err, 0);

    // Alternating single-cycle requests, then both after an idle cycle
    @(negedge clk);
    io.s_valid_i = 1; io.s_x_i = 16'h0AAA; io.s_tag_i = 4'd1;
    #1 chk("t3_s_ready", io.s_ready_o, 1);
    exp_s(16'h0AAA, 4'd1, 1);
    @(negedge clk);
    io.s_valid_i = 0; io.e_valid_i = 1; io.e_x_i = 16'h0BBB; io.e_tag_i = 4'd2;
    #1 chk("t3_e_ready", io.e_ready_o, 1);
    exp_e(16'h0BBB, 4'd2);
    #1 chk("t3_uv_first", io.u_valid_o, 1);
    @(negedge clk); io.e_valid_i = 0;
    #2 chk("t3_uv_second", io.u_valid_o, 1);
    @(negedge clk);
    io.s_valid_i = 1; io.s_x_i = 16'h0CCC; io.s_tag_i = 4'd3;
    io.e_valid_i = 1; io.e_x_i = 16'h0DDD; io.e_tag_i = 4'd4;
    #1;
    chk("t3_both_s_ready", io.s_ready_o, 1);
    chk("t3_both_e_ready", io.e_ready_o, 0);
    exp_s(16'h0CCC, 4'd3, 1);
    @(negedge clk); io.s_valid_i = 0; io.e_valid_i = 0;
    wait_drained("t3_drained");
    chk_queues("t3");

    // Drain after 10 accepts
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      io.s_valid_i = 1; io.s_x_i = 16'(16'h3000 + i); io.s_tag_i = 4'(i);
      #1 chk("t4_ready", io.s_ready_o, 1);
      exp_s(16'(16'h3000 + i), 4'(i), 1);
    end
    @(negedge clk);
    drain = 1; io.e_valid_i = 1; io.e_x_i = 16'h0EEE;
    #1;
    chk("t4_drain_s_ready", io.s_ready_o, 0);
    chk("t4_drain_e_ready", io.e_ready_o, 0);
    cnt_res = 0; hit = 0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk); #2;
      if (io.s_res_valid_o) begin
        cnt_res++;
        if (cnt_res == 10) begin
          hit = 1;
          chk("t4_drained_at_last", drained, 0);
        end
      end
    end
    chk("t4_res_count", cnt_res, 10);
    @(negedge clk); #2;
    chk("t4_drained_after", drained, 1);
    chk("t4_still_blocked", io.s_ready_o | io.e_ready_o, 0);
    @(negedge clk); io.s_valid_i = 0; io.e_valid_i = 0; drain = 0;
    chk_queues("t4");

    // Error: exp valid while the head is softplus
    @(negedge clk);
    io.s_valid_i = 1; io.s_x_i = 16'h4000; io.s_tag_i = 4'd7;
    #1 chk("t5a_ready", io.s_ready_o, 1);
    exp_s(16'h4000, 4'd7, 0);
    @(negedge clk); io.s_valid_i = 0;
    repeat (33) @(negedge clk);
    inj_e = 1;
    #2;
    chk("t5a_no_s_res", io.s_res_valid_o, 0);
    chk("t5a_no_e_res", io.e_res_valid_o, 0);
    chk("t5a_err_pre", err, 0);
    @(negedge clk); inj_e = 0;
    #2 chk("t5a_err", err, 1);
    repeat (5) @(negedge clk);
    #2 chk("t5a_err_sticky", err, 1);
    do_reset();
    #2 chk("t5a_err_clear", err, 0);

    // Error: unit drops the valid of an issued op
    @(negedge clk);
    io.s_valid_i = 1; io.s_x_i = 16'h5000; io.s_tag_i = 4'd9;
    #1 chk("t5b_ready", io.s_ready_o, 1);
    exp_s(16'h5000, 4'd9, 0);
    @(negedge clk); io.s_valid_i = 0;
    repeat (33) @(negedge clk);
    drop = 1;
    #2 chk("t5b_no_s_res", io.s_res_valid_o, 0);
    @(negedge clk); drop = 0;
    #2 chk("t5b_err", err, 1);
    repeat (5) @(negedge clk);
    #2 chk("t5b_err_sticky", err, 1);
    do_reset();
    #2 chk("t5b_err_clear", err, 0);

    // Reset with 5 ops in flight
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      io.s_valid_i = 1; io.s_x_i = 16'(16'h6000 + i); io.s_tag_i = 4'(i);
      #1 chk("t6_ready", io.s_ready_o, 1);
      exp_s(16'(16'h6000 + i), 4'(i), 0);
    end
    @(negedge clk); io.s_valid_i = 0;
    repeat (3) @(negedge clk);
    chk("t6_busy", drained, 0);
    rstn = 0; io.s_valid_i = 1; io.e_valid_i = 1;
    #1;
    chk("t6_rst_s_ready", io.s_ready_o, 0);
    chk("t6_rst_e_ready", io.e_ready_o, 0);
    @(negedge clk); rstn = 1; io.s_valid_i = 0; io.e_valid_i = 0;
    #2;
    chk("t6_u_valid", io.u_valid_o, 0);
    chk("t6_u_x", io.u_x_o, 0);
    chk("t6_u_mode", io.u_mode_softplus_o, 1);
    chk("t6_drained", drained, 1);
    chk("t6_err", err, 0);
    quiet = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk); #2;
      if (io.s_res_valid_o || io.e_res_valid_o) quiet++;
    end
    chk("t6_no_results", quiet, 0);
    chk("t6_drained_end", drained, 1);
    chk_queues("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
